// File: rtl/run_controller.sv
// Run controller: debounced buttons drive a READY/BUSY/PAUSED/HALTED FSM gating a divided clock to the core.
// Button presses act ~2+DB_CYCLES cycles after the raw edge; no backpressure, myclock only ever gated on whole phases.
module run_controller #(
    parameter int DIV_WIDTH = 21,
    parameter int DB_CYCLES = 65535,
    parameter int N_IRQ     = 4
) (
    input  logic             fpgaclock,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic             interrupt,
    input  logic             step,
    input  logic             mode,
    input  logic             halted,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] irq_mask,
    output logic             myclock,
    output logic             tick,
    output logic             ready,
    output logic             busy,
    output logic             interrupted,
    output logic             halt_st,
    output logic [N_IRQ-1:0] irq_src,
    output logic             step_mode
);
    localparam int NB      = 4;
    localparam int DBW     = $clog2(DB_CYCLES + 1);
    localparam int B_START = 0;
    localparam int B_CLEAR = 1;
    localparam int B_INT   = 2;
    localparam int B_STEP  = 3;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {S_READY, S_BUSY, S_PAUSED, S_HALTED} state_t;

    logic [NB-1:0]        btn_raw;
    logic [NB-1:0]        sync1_q, sync1_d, sync2_q, sync2_d, clean_q, clean_d, press;
    logic [DBW-1:0]       db_cnt_q [NB];
    logic [DBW-1:0]       db_cnt_d [NB];
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 msb, run_req, run_en_q, run_en_d;
    logic                 armed_q, armed_d, step_mode_q, step_mode_d;
    logic [N_IRQ-1:0]     irq_src_q, irq_src_d, irq_hit;
    state_t               state_q, state_d;

    assign btn_raw = {step, interrupt, clear, start};

    // A level change is accepted on the DB_CYCLES-th consecutive sample that differs from the clean level.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        clean_d = clean_q;
        press   = '0;
        for (int b = 0; b < NB; b++) begin
            db_cnt_d[b] = '0;
            if (sync2_q[b] != clean_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    clean_d[b] = sync2_q[b];
                    press[b]   = sync2_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    // run_en only moves while the MSB is low, so a high phase is either fully delivered or not at all.
    always_comb begin
        msb      = div_q[DIV_WIDTH-1];
        div_d    = div_q + 1'b1;
        run_req  = (state_q == S_BUSY) && (!step_mode_q || armed_q);
        run_en_d = msb ? run_en_q : run_req;
    end

    assign myclock     = msb & run_en_q;
    assign tick        = myclock && (div_q[DIV_WIDTH-2:0] == '0);
    assign irq_hit     = irq & irq_mask;
    assign ready       = (state_q == S_READY);
    assign busy        = (state_q == S_BUSY);
    assign interrupted = (state_q == S_PAUSED);
    assign halt_st     = (state_q == S_HALTED);
    assign irq_src     = irq_src_q;
    assign step_mode   = step_mode_q;

    always_comb begin
        state_d     = state_q;
        irq_src_d   = irq_src_q;
        step_mode_d = step_mode_q;
        armed_d     = tick ? 1'b0 : armed_q;
        case (state_q)
            S_READY: begin
                if (press[B_START]) begin
                    state_d     = S_BUSY;
                    step_mode_d = mode;
                    irq_src_d   = '0;
                end
            end
            S_BUSY: begin
                if (press[B_CLEAR]) begin
                    state_d   = S_READY;
                    irq_src_d = '0;
                end else if (press[B_INT] || (|irq_hit)) begin
                    state_d   = S_PAUSED;
                    irq_src_d = irq_hit;
                end else if (halted) begin
                    state_d = S_HALTED;
                end else if (press[B_STEP] && step_mode_q && !armed_q) begin
                    armed_d = 1'b1;
                end
            end
            S_PAUSED: begin
                if (press[B_CLEAR]) begin
                    state_d   = S_READY;
                    irq_src_d = '0;
                end else if (press[B_INT]) begin
                    state_d = S_BUSY;
                end
            end
            S_HALTED: begin
                if (press[B_CLEAR]) begin
                    state_d   = S_READY;
                    irq_src_d = '0;
                end else if (press[B_START] && !halted) begin
                    state_d = S_BUSY;
                end
            end
            default: state_d = S_READY;
        endcase
        if (state_d != S_BUSY) armed_d = 1'b0;
    end

    always_ff @(posedge fpgaclock or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            clean_q     <= '0;
            for (int b = 0; b < NB; b++) db_cnt_q[b] <= '0;
            div_q       <= '0;
            run_en_q    <= 1'b0;
            armed_q     <= 1'b0;
            step_mode_q <= 1'b0;
            irq_src_q   <= '0;
            state_q     <= S_READY;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            clean_q     <= clean_d;
            for (int b = 0; b < NB; b++) db_cnt_q[b] <= db_cnt_d[b];
            div_q       <= div_d;
            run_en_q    <= run_en_d;
            armed_q     <= armed_d;
            step_mode_q <= step_mode_d;
            irq_src_q   <= irq_src_d;
            state_q     <= state_d;
        end
    end
endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: directed scenarios plus random button/irq traffic against a behavioural model.
module tb_run_controller;
    localparam int DW     = 4;
    localparam int DB     = 4;
    localparam int NI     = 4;
    localparam int PERIOD = 1 << DW;
    localparam int HALF   = PERIOD / 2;

    logic          fpgaclock = 1'b0;
    logic          reset     = 1'b0;
    logic [3:0]    btn       = '0;  // {step, interrupt, clear, start}
    logic          mode      = 1'b0;
    logic          halted    = 1'b0;
    logic [NI-1:0] irq       = '0;
    logic [NI-1:0] irq_mask  = '0;
    logic          myclock, tick, ready, busy, interrupted, halt_st, step_mode;
    logic [NI-1:0] irq_src;
    logic [10:0]   dut_vec;

    int          checks = 0, errors = 0;
    int          lock_miss = 0;
    logic [10:0] lock_got, lock_exp;
    int          tick_cnt = 0, hi_cnt = 0;

    always #5 fpgaclock = ~fpgaclock;

    run_controller #(.DIV_WIDTH(DW), .DB_CYCLES(DB), .N_IRQ(NI)) dut (
        .fpgaclock(fpgaclock), .reset(reset),
        .start(btn[0]), .clear(btn[1]), .interrupt(btn[2]), .step(btn[3]),
        .mode(mode), .halted(halted), .irq(irq), .irq_mask(irq_mask),
        .myclock(myclock), .tick(tick), .ready(ready), .busy(busy),
        .interrupted(interrupted), .halt_st(halt_st), .irq_src(irq_src), .step_mode(step_mode)
    );

    assign dut_vec = {myclock, tick, ready, busy, interrupted, halt_st, irq_src, step_mode};

    // Behavioural model: button = raw level delayed two edges, accepted after DB equal samples.
    typedef enum int {M_READY, M_BUSY, M_PAUSED, M_HALTED} mst_t;
    mst_t        m_st = M_READY;
    int          m_cnt = 0;
    bit          m_run = 0, m_armed = 0, m_smode = 0;
    bit [NI-1:0] m_src = '0;
    bit [3:0]    m_h1 = '0, m_h2 = '0, m_last = '0, m_clean = '0;
    int          m_len [4];

    task automatic model_reset();
        m_st = M_READY; m_cnt = 0; m_run = 0; m_armed = 0; m_smode = 0; m_src = '0;
        m_h1 = '0; m_h2 = '0; m_last = '0; m_clean = '0;
        for (int b = 0; b < 4; b++) m_len[b] = 0;
    endtask

    task automatic model_edge();
        bit [3:0]    pr;
        bit          x, tk, req, armed_pre;
        bit [NI-1:0] hit;
        if (reset !== 1'b1) begin
            model_reset();
            return;
        end
        pr = '0;
        for (int b = 0; b < 4; b++) begin
            x = m_h2[b];
            m_len[b] = (x == m_last[b]) ? m_len[b] + 1 : 1;
            m_last[b] = x;
            if (x != m_clean[b] && m_len[b] >= DB) begin
                m_clean[b] = x;
                pr[b] = x;
            end
        end
        m_h2 = m_h1;
        m_h1 = btn;
        tk        = m_run && (m_cnt == HALF);
        req       = (m_st == M_BUSY) && (m_smode ? m_armed : 1'b1);
        hit       = irq & irq_mask;
        armed_pre = m_armed;
        if (tk) m_armed = 0;
        case (m_st)
            M_READY:  if (pr[0]) begin m_st = M_BUSY; m_smode = mode; m_src = '0; end
            M_BUSY: begin
                if (pr[1]) begin m_st = M_READY; m_src = '0; end
                else if (pr[2] || hit != 0) begin m_st = M_PAUSED; m_src = hit; end
                else if (halted) m_st = M_HALTED;
                else if (pr[3] && m_smode && !armed_pre) m_armed = 1;
            end
            M_PAUSED: begin
                if (pr[1]) begin m_st = M_READY; m_src = '0; end
                else if (pr[2]) m_st = M_BUSY;
            end
            default: begin
                if (pr[1]) begin m_st = M_READY; m_src = '0; end
                else if (pr[0] && !halted) m_st = M_BUSY;
            end
        endcase
        if (m_st != M_BUSY) m_armed = 0;
        if (m_cnt < HALF) m_run = req;
        m_cnt = (m_cnt + 1) % PERIOD;
    endtask

    function automatic logic [10:0] exp_vec();
        logic mc;
        mc = m_run && (m_cnt >= HALF);
        return {mc, mc && (m_cnt == HALF), m_st == M_READY, m_st == M_BUSY,
                m_st == M_PAUSED, m_st == M_HALTED, m_src, m_smode};
    endfunction

    task automatic cyc();
        logic [10:0] e;
        model_edge();
        @(posedge fpgaclock);
        #1;
        e = exp_vec();
        if (dut_vec !== e) begin lock_miss++; lock_got = dut_vec; lock_exp = e; end
        tick_cnt += (tick === 1'b1) ? 1 : 0;
        hi_cnt   += (myclock === 1'b1) ? 1 : 0;
    endtask

    task automatic press(input logic [3:0] m, input int k);
        btn = btn | m;
        repeat (k) cyc();
        btn = btn & ~m;
        repeat (8) cyc();
    endtask

    task automatic apply_reset();
        btn = '0; halted = 0; irq = '0;
        reset = 1'b0;
        repeat (3) cyc();
        reset = 1'b1;
        repeat (2) cyc();
    endtask

    task automatic test_reset();
        btn = '0; mode = 0; halted = 0; irq = '0; irq_mask = '0;
        reset = 1'b0; #1; model_reset();
        checks++;
        if (dut_vec !== 11'h100) begin errors++; $display("FAIL reset_hold: got %b want %b", dut_vec, 11'h100); end
        repeat (3) cyc();
        reset = 1'b1;
        repeat (2) cyc();
        checks++;
        if (dut_vec !== 11'h100) begin errors++; $display("FAIL reset_release: got %b want %b", dut_vec, 11'h100); end
        checks++;
        if (lock_miss != 0) begin errors++; $display("FAIL lock_reset: %0d cycles, got %b want %b", lock_miss, lock_got, lock_exp); end
        lock_miss = 0;
    endtask

    task automatic test_continuous();
        mode = 0;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL cont_ready_before: got %b want 1", ready); end
        press(4'b0001, 10);
        checks++;
        if (ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL cont_busy: got ready=%b busy=%b want 0 1", ready, busy); end
        for (int i = 0; i < 2 * PERIOD && tick !== 1'b1; i++) cyc();
        checks++;
        if (tick !== 1'b1) begin errors++; $display("FAIL cont_tick_seen: got %b want 1", tick); end
        tick_cnt = 0; hi_cnt = 0;
        repeat (2 * PERIOD) cyc();
        checks++;
        if (tick_cnt != 2) begin errors++; $display("FAIL cont_ticks: got %0d want 2", tick_cnt); end
        checks++;
        if (hi_cnt != PERIOD) begin errors++; $display("FAIL cont_high: got %0d want %0d", hi_cnt, PERIOD); end
        checks++;
        if (lock_miss != 0) begin errors++; $display("FAIL lock_cont: %0d cycles, got %b want %b", lock_miss, lock_got, lock_exp); end
        lock_miss = 0;
    endtask

    task automatic test_irq_pause();
        logic [NI-1:0] want;
        int            k;
        irq_mask = 4'b0100; irq = 4'b0110;
        cyc();
        irq = '0;
        checks++;
        if (interrupted !== 1'b1 || irq_src !== 4'b0100) begin
            errors++; $display("FAIL irq_pause: got int=%b src=%b want 1 0100", interrupted, irq_src);
        end
        repeat (PERIOD) cyc();
        hi_cnt = 0;
        repeat (PERIOD) cyc();
        checks++;
        if (hi_cnt != 0) begin errors++; $display("FAIL irq_clock_gated: got %0d high cycles want 0", hi_cnt); end
        press(4'b0100, 10);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL irq_resume: got busy=%b want 1", busy); end
        for (int r = 0; r < 3; r++) begin
            k = $urandom_range(0, NI - 1);
            repeat ($urandom_range(1, 20)) cyc();
            irq_mask = NI'($urandom) | (NI'(1) << k);
            irq      = NI'($urandom) | (NI'(1) << k);
            want     = irq & irq_mask;
            cyc();
            irq = '0;
            checks++;
            if (interrupted !== 1'b1 || irq_src !== want) begin
                errors++; $display("FAIL irq_rand_src: got int=%b src=%b want 1 %b", interrupted, irq_src, want);
            end
            press(4'b0100, 10);
        end
        checks++;
        if (lock_miss != 0) begin errors++; $display("FAIL lock_irq: %0d cycles, got %b want %b", lock_miss, lock_got, lock_exp); end
        lock_miss = 0;
    endtask

    task automatic test_step();
        apply_reset();
        mode = 1; irq_mask = '0;
        press(4'b0001, 10);
        checks++;
        if (busy !== 1'b1 || step_mode !== 1'b1) begin errors++; $display("FAIL step_enter: got busy=%b step_mode=%b want 1 1", busy, step_mode); end
        tick_cnt = 0; hi_cnt = 0;
        repeat (40) cyc();
        checks++;
        if (tick_cnt != 0 || hi_cnt != 0) begin errors++; $display("FAIL step_idle: got ticks=%0d high=%0d want 0 0", tick_cnt, hi_cnt); end
        press(4'b1000, 6);
        repeat (26) cyc();
        press(4'b1000, 6);
        repeat (40) cyc();
        checks++;
        if (tick_cnt != 2) begin errors++; $display("FAIL step_ticks: got %0d want 2", tick_cnt); end
        checks++;
        if (hi_cnt != 2 * HALF) begin errors++; $display("FAIL step_high: got %0d want %0d", hi_cnt, 2 * HALF); end
        checks++;
        if (lock_miss != 0) begin errors++; $display("FAIL lock_step: %0d cycles, got %b want %b", lock_miss, lock_got, lock_exp); end
        lock_miss = 0;
    endtask

    task automatic test_halt();
        apply_reset();
        mode = 0;
        press(4'b0001, 10);
        halted = 1;
        cyc();
        checks++;
        if (halt_st !== 1'b1) begin errors++; $display("FAIL halt_enter: got %b want 1", halt_st); end
        press(4'b0001, 10);
        checks++;
        if (halt_st !== 1'b1) begin errors++; $display("FAIL halt_start_blocked: got %b want 1", halt_st); end
        halted = 0;
        repeat (4) cyc();
        checks++;
        if (halt_st !== 1'b1) begin errors++; $display("FAIL halt_no_autoresume: got %b want 1", halt_st); end
        press(4'b0001, 10);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL halt_restart: got busy=%b want 1", busy); end
        checks++;
        if (lock_miss != 0) begin errors++; $display("FAIL lock_halt: %0d cycles, got %b want %b", lock_miss, lock_got, lock_exp); end
        lock_miss = 0;
    endtask

    task automatic test_clear_int();
        irq_mask = 4'b0011; irq = 4'b0001;
        cyc();
        irq = '0;
        press(4'b0100, 10);
        checks++;
        if (busy !== 1'b1 || irq_src !== 4'b0001) begin errors++; $display("FAIL src_held: got busy=%b src=%b want 1 0001", busy, irq_src); end
        press(4'b0110, 10);
        checks++;
        if (ready !== 1'b1 || irq_src !== 4'b0000) begin errors++; $display("FAIL clear_wins: got ready=%b src=%b want 1 0000", ready, irq_src); end
        checks++;
        if (lock_miss != 0) begin errors++; $display("FAIL lock_clear: %0d cycles, got %b want %b", lock_miss, lock_got, lock_exp); end
        lock_miss = 0;
    endtask

    task automatic test_bounce();
        apply_reset();
        mode = 0; irq_mask = '0;
        repeat (5) begin btn = 4'b0001; repeat (3) cyc(); btn = '0; repeat (3) cyc(); end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL bounce_start: got ready=%b want 1", ready); end
        press(4'b0001, 10);
        repeat (5) begin btn = 4'b0110; repeat (3) cyc(); btn = '0; repeat (3) cyc(); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL bounce_clear_int: got busy=%b want 1", busy); end
        checks++;
        if (lock_miss != 0) begin errors++; $display("FAIL lock_bounce: %0d cycles, got %b want %b", lock_miss, lock_got, lock_exp); end
        lock_miss = 0;
    endtask

    task automatic test_random();
        int hold [4];
        int onehot_bad;
        onehot_bad = 0;
        for (int b = 0; b < 4; b++) hold[b] = 0;
        apply_reset();
        irq_mask = NI'($urandom);
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold[b] > 0) begin
                    hold[b]--;
                    if (hold[b] == 0) btn[b] = 1'b0;
                end else if ($urandom_range(0, 24) == 0) begin
                    btn[b]  = 1'b1;
                    hold[b] = $urandom_range(1, 12);
                end
            end
            if ($urandom_range(0, 39) == 0) halted = ~halted;
            if ($urandom_range(0, 59) == 0) mode = ~mode;
            irq = ($urandom_range(0, 49) == 0) ? NI'($urandom) : '0;
            cyc();
            if (int'(ready) + int'(busy) + int'(interrupted) + int'(halt_st) != 1) onehot_bad++;
        end
        btn = '0; halted = 0; irq = '0;
        checks++;
        if (onehot_bad != 0) begin errors++; $display("FAIL rand_onehot: got %0d bad cycles want 0", onehot_bad); end
        checks++;
        if (lock_miss != 0) begin errors++; $display("FAIL lock_random: %0d cycles, got %b want %b", lock_miss, lock_got, lock_exp); end
        lock_miss = 0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        mode = 0; irq_mask = 4'b1111;
        press(4'b0001, 10);
        for (int i = 0; i < 2 * PERIOD && myclock !== 1'b1; i++) cyc();
        checks++;
        if (myclock !== 1'b1) begin errors++; $display("FAIL mid_high_seen: got %b want 1", myclock); end
        #2 reset = 1'b0;
        #1 model_reset();
        checks++;
        if (dut_vec !== 11'h100) begin errors++; $display("FAIL reset_mid_busy: got %b want %b", dut_vec, 11'h100); end
        hi_cnt = 0;
        repeat (5) cyc();
        reset = 1'b1;
        repeat (20) cyc();
        checks++;
        if (hi_cnt != 0 || ready !== 1'b1) begin errors++; $display("FAIL reset_after: got high=%0d ready=%b want 0 1", hi_cnt, ready); end
        checks++;
        if (lock_miss != 0) begin errors++; $display("FAIL lock_reset_mid: %0d cycles, got %b want %b", lock_miss, lock_got, lock_exp); end
        lock_miss = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_continuous();
        test_irq_pause();
        test_step();
        test_halt();
        test_clear_int();
        test_bounce();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 21: divider counter width; divided clock period = 2^DIV_WIDTH fpgaclock cycles.
REQ-002 SHALL have parameter DB_CYCLES, default 65535: consecutive identical samples required to accept a button level change.
REQ-003 SHALL have parameter N_IRQ, default 4: number of external interrupt request lines.
REQ-004 fpgaclock  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low; 0 forces every register to its reset value immediately.
REQ-006 start, clear, interrupt, step  in  1 each  raw push-buttons, asynchronous to fpgaclock.
REQ-007 mode  in  1  0 = continuous run, 1 = single-step; sampled only while in READY.
REQ-008 halted  in  1  halt request from main core, synchronous to fpgaclock, level.
REQ-009 irq, irq_mask  in  N_IRQ each  request lines (level, synchronous) and per-line enable.
REQ-010 myclock  out  1  gated divided clock to main core.
REQ-011 tick  out  1  one-fpgaclock pulse coincident with each rising edge delivered on myclock.
REQ-012 ready, busy, interrupted, halt_st  out  1 each  one-hot state flags.
REQ-013 irq_src  out  N_IRQ  latched masked irq lines that caused the last pause.
REQ-014 step_mode  out  1  registered copy of mode.

Function
REQ-015 Each button SHALL pass a 2-FF synchroniser, then a debouncer updating its clean level after DB_CYCLES equal samples; a press pulse SHALL be one cycle on the clean 0->1 edge.
REQ-016 Divider counter SHALL free-run from 0, increment every cycle, wrap 2^DIV_WIDTH-1 -> 0, ignoring state.
REQ-017 Internal run_en SHALL update only in cycles where counter MSB is 0, so myclock never emits a truncated high phase.
REQ-018 myclock SHALL equal counter MSB AND run_en; tick SHALL assert in the cycle the counter goes from 2^(DIV_WIDTH-1)-1 to 2^(DIV_WIDTH-1) while run_en is 1.
REQ-019 FSM states SHALL be READY, BUSY, PAUSED, HALTED; exactly one flag asserted.
REQ-020 READY: start press -> BUSY, latch mode into step_mode, clear irq_src.
REQ-021 BUSY: interrupt press, or any (irq & irq_mask) bit set -> PAUSED, latching irq & irq_mask into irq_src (zero on button-only pause).
REQ-022 BUSY: halted=1 -> HALTED.
REQ-023 PAUSED: interrupt press -> BUSY; irq_src held until next pause or READY entry.
REQ-024 HALTED: start press -> BUSY only if halted=0; otherwise stay.
REQ-025 clear press in BUSY, PAUSED or HALTED SHALL go to READY; ignored in READY.
REQ-026 Same-cycle events priority: clear > interrupt press / irq > halted > step press.
REQ-027 Continuous mode: requested run_en SHALL be 1 only in BUSY.
REQ-028 Step mode: step press in BUSY SHALL arm one step; run_en requested 1 until exactly one tick issued, then 0; presses while armed ignored.
REQ-029 Leaving BUSY SHALL disarm any pending step; re-entering BUSY in step mode SHALL start disarmed.
REQ-030 start in BUSY/PAUSED, step in continuous mode or outside BUSY, interrupt in READY/HALTED SHALL be ignored.

Reset
REQ-031 On reset=0: state READY, ready=1, busy=interrupted=halt_st=0, run_en=0, myclock=0, tick=0, divider=0, irq_src=0, step_mode=0, synchroniser/debouncer levels 0, step disarmed.
REQ-032 Reset asserted mid-BUSY SHALL drop myclock to 0 the same instant, no glitch afterwards.

Verification (DIV_WIDTH=4, DB_CYCLES=4, N_IRQ=4)
REQ-033 Reset, mode=0, start held 10 cycles -> ready 1->0, busy=1, myclock 8-high/8-low, one tick per 16 cycles.
REQ-034 BUSY, irq=4'b0110, irq_mask=4'b0100 -> PAUSED, irq_src=4'b0100, myclock low from next MSB-low window; interrupt press -> BUSY.
REQ-035 mode=1, start, then two step presses 40 cycles apart -> exactly two ticks, two myclock pulses each 8 cycles wide.
REQ-036 BUSY, halted=1 -> HALTED; start while halted=1 stays; halted=0 then start -> BUSY.
REQ-037 clear and interrupt pressed same cycle in BUSY -> READY, irq_src=0.
REQ-038 Button bouncing 3-cycle pulses -> no state change; reset=0 while myclock high -> myclock 0 at once, all outputs at reset values.
